// File: rtl/keypoint_frame_counter.sv
// keypoint_frame_counter
//   Producer side of the per-frame keypoint-count interface. Accumulates
//   keypoints flagged by the detector lanes while a frame is open and, at
//   frame end, publishes the saturated total plus the warm-up level used by
//   the adaptive threshold controller.
//
//   Optional feature macro: KP_AVG_EN adds kp_avg, the mean of the last four
//   published counts.
//
// Ports
//   clk             clock
//   rst_n           synchronous active-low reset
//   frame_start     single-cycle pulse, opens a frame
//   frame_end       single-cycle pulse, closes the open frame
//   kp_valid        per-lane keypoint flags, sampled every cycle
//   keypoint_num    count of the last completed frame
//   num_valid       one-cycle pulse when keypoint_num updates
//   adaptive_toggle level, high once WARMUP_FRAMES frames have completed
//   frame_active    high while a frame is open
//   cnt_overflow    sticky saturation flag, cleared when a frame starts
//   frame_abort     one-cycle pulse on watchdog timeout or restart
//   kp_avg          (KP_AVG_EN only) mean of the last four published counts
module keypoint_frame_counter #(
  parameter int unsigned LANES          = 2,
  parameter int unsigned CNT_W          = 11,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned WARMUP_FRAMES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic [LANES-1:0] kp_valid,
  output logic [CNT_W-1:0] keypoint_num,
  output logic             num_valid,
  output logic             adaptive_toggle,
  output logic             frame_active,
  output logic             cnt_overflow,
  output logic             frame_abort
`ifdef KP_AVG_EN
  ,
  output logic [CNT_W-1:0] kp_avg
`endif
);

  localparam int unsigned PC_W  = (LANES > 1) ? $clog2(LANES + 1) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WU_W  = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] acc, acc_nxt;
  logic [WD_W-1:0]  wd, wd_nxt;
  logic [WU_W-1:0]  wu, wu_nxt;
  logic             pend, pend_nxt;
  logic [CNT_W-1:0] num_nxt;
  logic             nv_nxt, tog_nxt, act_nxt, ovf_nxt, abort_nxt;

  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] sum;
  logic             sat;
  logic [CNT_W-1:0] acc_sat;
  logic             wd_last;

  // Lane popcount for the current cycle
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + PC_W'(kp_valid[i]);
    end
  end

  // Widened add, clamped to the saturation value
  always_comb begin
    sum     = SUM_W'(acc) + SUM_W'(pop);
    sat     = (sum >= SUM_W'(CNT_MAX));
    acc_sat = sat ? CNT_MAX : sum[CNT_W-1:0];
    wd_last = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      acc             <= '0;
      wd              <= '0;
      wu              <= '0;
      pend            <= 1'b0;
      keypoint_num    <= '0;
      num_valid       <= 1'b0;
      adaptive_toggle <= 1'b0;
      frame_active    <= 1'b0;
      cnt_overflow    <= 1'b0;
      frame_abort     <= 1'b0;
    end else begin
      state           <= state_nxt;
      acc             <= acc_nxt;
      wd              <= wd_nxt;
      wu              <= wu_nxt;
      pend            <= pend_nxt;
      keypoint_num    <= num_nxt;
      num_valid       <= nv_nxt;
      adaptive_toggle <= tog_nxt;
      frame_active    <= act_nxt;
      cnt_overflow    <= ovf_nxt;
      frame_abort     <= abort_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    wd_nxt    = wd;
    wu_nxt    = wu;
    pend_nxt  = pend;
    num_nxt   = keypoint_num;
    nv_nxt    = 1'b0;
    tog_nxt   = adaptive_toggle;
    ovf_nxt   = cnt_overflow;
    abort_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = COUNT;
          acc_nxt   = CNT_W'(pop);
          wd_nxt    = '0;
          ovf_nxt   = 1'b0;
        end
      end

      COUNT: begin
        acc_nxt = acc_sat;
        wd_nxt  = wd + WD_W'(1);
        if (sat) ovf_nxt = 1'b1;
        if (frame_end) begin
          // A coincident start opens the next frame right after publishing
          state_nxt = PUBLISH;
          pend_nxt  = frame_start;
        end else if (frame_start) begin
          abort_nxt = 1'b1;
          acc_nxt   = CNT_W'(pop);
          wd_nxt    = '0;
          ovf_nxt   = 1'b0;
        end else if (wd_last) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
          wd_nxt    = '0;
        end
      end

      PUBLISH: begin
        num_nxt  = acc;
        nv_nxt   = 1'b1;
        pend_nxt = 1'b0;
        if (wu != WU_W'(WARMUP_FRAMES)) wu_nxt = wu + WU_W'(1);
        if (wu_nxt == WU_W'(WARMUP_FRAMES)) tog_nxt = 1'b1;
        if (pend || frame_start) begin
          state_nxt = COUNT;
          acc_nxt   = CNT_W'(pop);
          wd_nxt    = '0;
          ovf_nxt   = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    act_nxt = (state_nxt == COUNT);
  end

`ifdef KP_AVG_EN
  localparam int unsigned AVG_W = CNT_W + 2;

  logic [CNT_W-1:0] hist [4];
  logic [AVG_W-1:0] hist_sum;

  always_comb begin
    hist_sum = AVG_W'(hist[0]) + AVG_W'(hist[1]) + AVG_W'(hist[2]) + AVG_W'(hist[3]);
  end

  // History shifts on publish; the average follows one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      kp_avg <= '0;
    end else begin
      if (state == PUBLISH) begin
        hist[0] <= acc;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
      end
      kp_avg <= hist_sum[AVG_W-1:2];
    end
  end
`endif

endmodule

// File: tb/tb_keypoint_frame_counter.sv
module tb_keypoint_frame_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        frame_end;
  logic [1:0]  kp_valid;

  logic [10:0] keypoint_num, keypoint_num_t;
  logic        num_valid, num_valid_t;
  logic        adaptive_toggle, adaptive_toggle_t;
  logic        frame_active, frame_active_t;
  logic        cnt_overflow, cnt_overflow_t;
  logic        frame_abort, frame_abort_t;
`ifdef KP_AVG_EN
  logic [10:0] kp_avg, kp_avg_t;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypoint_frame_counter dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .kp_valid(kp_valid), .keypoint_num(keypoint_num), .num_valid(num_valid),
    .adaptive_toggle(adaptive_toggle), .frame_active(frame_active),
    .cnt_overflow(cnt_overflow), .frame_abort(frame_abort)
`ifdef KP_AVG_EN
    , .kp_avg(kp_avg)
`endif
  );

  keypoint_frame_counter #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .kp_valid(kp_valid), .keypoint_num(keypoint_num_t), .num_valid(num_valid_t),
    .adaptive_toggle(adaptive_toggle_t), .frame_active(frame_active_t),
    .cnt_overflow(cnt_overflow_t), .frame_abort(frame_abort_t)
`ifdef KP_AVG_EN
    , .kp_avg(kp_avg_t)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        fs;
    logic        fe;
    logic [1:0]  kp;
    logic [10:0] num;
    logic        nv;
    logic        tog;
    logic        act;
    logic        ovf;
    logic        ab;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Packed view {num, nv, tog, act, ovf, abort}
  function automatic logic [31:0] pack(input logic [10:0] n, input logic nv, input logic tg,
                                       input logic ac, input logic ov, input logic ab);
    return 32'({n, nv, tg, ac, ov, ab});
  endfunction

  function automatic logic [31:0] main_out();
    return pack(keypoint_num, num_valid, adaptive_toggle, frame_active, cnt_overflow, frame_abort);
  endfunction

  function automatic logic [31:0] to_out();
    return pack(keypoint_num_t, num_valid_t, adaptive_toggle_t, frame_active_t, cnt_overflow_t,
                frame_abort_t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic fs, input logic fe, input logic [1:0] kp,
                     input int num, input logic nv, input logic tg, input logic ac,
                     input logic ov, input logic ab, input string nm);
    vec_t v;
    v.rst_n = r; v.fs = fs; v.fe = fe; v.kp = kp;
    v.num = 11'(num); v.nv = nv; v.tog = tg; v.act = ac; v.ovf = ov; v.ab = ab; v.name = nm;
    vecs.push_back(v);
  endtask

  // Apply inputs, then sample 1 time unit after the next rising edge
  task automatic step(input logic r, input logic fs, input logic fe, input logic [1:0] kp);
    rst_n = r; frame_start = fs; frame_end = fe; kp_valid = kp;
    @(posedge clk);
    #1;
  endtask

`ifdef KP_AVG_EN
  task automatic avg_frame(input int cnt, input int exp_avg);
    step(1, 1, 0, 2'b00);
    for (int i = 0; i < cnt / 2; i++) step(1, 0, 0, 2'b11);
    step(1, 0, 1, 2'b00);
    step(1, 0, 0, 2'b00);
    chk("avg_num", 32'(keypoint_num), 32'(cnt));
    step(1, 0, 0, 2'b00);
    chk("kp_avg", 32'(kp_avg), 32'(exp_avg));
  endtask
`endif

  initial begin
    int first_abort;
    int abort_cnt;
    bit nv_seen;

    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; kp_valid = 2'b00;

    // ---- table: reset, basic frame, restart, coincident start/end ----
    add(0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, "reset");
    add(1, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, "idle_ignores_end");
    add(1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0, "t1_start");
    for (int i = 0; i < 9; i++) add(1, 0, 0, 2'b11, 0, 0, 0, 1, 0, 0, "t1_count");
    add(1, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, "t1_end");
    add(1, 0, 0, 2'b11, 20, 1, 1, 0, 0, 0, "t1_publish");
    add(1, 0, 0, 2'b00, 20, 0, 1, 0, 0, 0, "t1_hold");

    add(1, 1, 0, 2'b01, 20, 0, 1, 1, 0, 0, "t3_start");
    add(1, 0, 0, 2'b11, 20, 0, 1, 1, 0, 0, "t3_c1");
    add(1, 0, 0, 2'b11, 20, 0, 1, 1, 0, 0, "t3_c2");
    add(1, 1, 0, 2'b01, 20, 0, 1, 1, 0, 1, "t3_restart");
    add(1, 0, 0, 2'b01, 20, 0, 1, 1, 0, 0, "t3_c3");
    add(1, 0, 1, 2'b01, 20, 0, 1, 0, 0, 0, "t3_end");
    add(1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0, "t3_publish");

    add(1, 1, 0, 2'b00, 3, 0, 1, 1, 0, 0, "t4_start");
    for (int i = 0; i < 3; i++) add(1, 0, 0, 2'b11, 3, 0, 1, 1, 0, 0, "t4_count");
    add(1, 0, 0, 2'b01, 3, 0, 1, 1, 0, 0, "t4_c7");
    add(1, 1, 1, 2'b00, 3, 0, 1, 0, 0, 0, "t4_start_end");
    add(1, 0, 0, 2'b10, 7, 1, 1, 1, 0, 0, "t4_publish_reopen");
    add(1, 0, 1, 2'b01, 7, 0, 1, 0, 0, 0, "t4_end2");
    add(1, 0, 0, 2'b00, 2, 1, 1, 0, 0, 0, "t4_publish2");

    add(1, 1, 0, 2'b00, 2, 0, 1, 1, 0, 0, "pub_start_open");
    add(1, 0, 1, 2'b01, 2, 0, 1, 0, 0, 0, "pub_start_end");
    add(1, 1, 0, 2'b11, 1, 1, 1, 1, 0, 0, "pub_start_in_publish");
    add(1, 0, 1, 2'b00, 1, 0, 1, 0, 0, 0, "pub_start_end2");
    add(1, 0, 0, 2'b00, 2, 1, 1, 0, 0, 0, "pub_start_publish2");
    add(1, 0, 0, 2'b11, 2, 0, 1, 0, 0, 0, "idle_hold");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].fs, vecs[i].fe, vecs[i].kp);
      chk(vecs[i].name, main_out(),
          pack(vecs[i].num, vecs[i].nv, vecs[i].tog, vecs[i].act, vecs[i].ovf, vecs[i].ab));
    end

    // ---- saturation: reach 2047 exactly, then stay clamped ----
    step(1, 1, 0, 2'b11);
    for (int i = 0; i < 1022; i++) step(1, 0, 0, 2'b11);
    chk("sat_below", main_out(), pack(2, 0, 1, 1, 0, 0));
    step(1, 0, 0, 2'b01);
    chk("sat_reached", main_out(), pack(2, 0, 1, 1, 1, 0));
    for (int i = 0; i < 76; i++) step(1, 0, 0, 2'b11);
    step(1, 0, 1, 2'b11);
    step(1, 0, 0, 2'b00);
    chk("sat_publish", main_out(), pack(2047, 1, 1, 0, 1, 0));
    step(1, 0, 0, 2'b00);
    chk("sat_sticky", main_out(), pack(2047, 0, 1, 0, 1, 0));
    step(1, 1, 0, 2'b00);
    chk("sat_clear_on_start", main_out(), pack(2047, 0, 1, 1, 0, 0));
    step(1, 0, 1, 2'b00);
    step(1, 0, 0, 2'b00);
    chk("empty_frame", main_out(), pack(0, 1, 1, 0, 0, 0));

    // ---- watchdog on the 16-cycle instance ----
    step(0, 0, 0, 2'b00);
    chk("to_reset", to_out(), 32'd0);
    step(1, 1, 0, 2'b11);
    step(1, 0, 1, 2'b00);
    step(1, 0, 0, 2'b00);
    chk("to_publish", to_out(), pack(2, 1, 1, 0, 0, 0));
    step(1, 1, 0, 2'b01);
    chk("to_open", to_out(), pack(2, 0, 1, 1, 0, 0));
    first_abort = -1;
    abort_cnt = 0;
    nv_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 0, 2'b11);
      if (frame_abort_t) begin
        abort_cnt++;
        if (first_abort < 0) first_abort = k;
      end
      if (num_valid_t) nv_seen = 1'b1;
    end
    chk("to_abort_cycle", 32'(first_abort), 32'd16);
    chk("to_abort_once", 32'(abort_cnt), 32'd1);
    chk("to_no_publish", 32'(nv_seen), 32'd0);
    chk("to_idle_hold", to_out(), pack(2, 0, 1, 0, 0, 0));

    // ---- reset mid-frame ----
    step(1, 1, 0, 2'b11);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2'b11);
    step(0, 0, 0, 2'b11);
    chk("midreset_main", main_out(), 32'd0);
    chk("midreset_to", to_out(), 32'd0);
    step(1, 0, 1, 2'b11);
    chk("midreset_no_publish", main_out(), 32'd0);

`ifdef KP_AVG_EN
    avg_frame(100, 25);
    avg_frame(200, 75);
    avg_frame(300, 150);
    avg_frame(400, 250);
    avg_frame(0, 225);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypoint_frame_counter.md
Name: keypoint_frame_counter

Overview:
Producer side of the per-frame keypoint-count interface. Counts keypoints reported by the detector lanes during one frame. At frame end it publishes the 11-bit total and the enable level consumed by the adaptive threshold controller. Sits between the extrema/keypoint detector and the threshold controller.

Parameters:
LANES, 2, number of parallel detector lanes; each may flag one keypoint per cycle.
CNT_W, 11, width of the published count; saturation value is 2^CNT_W-1 (2047).
TIMEOUT_CYCLES, 1048576, maximum cycles a frame may stay open before it is aborted.
WARMUP_FRAMES, 1, completed frames required before adaptive_toggle asserts.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
frame_start  in  1  single-cycle pulse; opens a frame
frame_end  in  1  single-cycle pulse; closes the open frame
kp_valid  in  LANES  per-lane keypoint flag, sampled every cycle
keypoint_num  out  CNT_W  count of the last completed frame; registered
num_valid  out  1  one-cycle pulse when keypoint_num updates
adaptive_toggle  out  1  level; high once WARMUP_FRAMES frames have completed
frame_active  out  1  high while a frame is open
cnt_overflow  out  1  sticky; set if any frame saturated; cleared on frame_start
frame_abort  out  1  one-cycle pulse on timeout or restart abort

Behaviour:
- Reset values (rst_n low at clk edge):
  - state=IDLE; keypoint_num=0, num_valid=0, adaptive_toggle=0, frame_active=0, cnt_overflow=0, frame_abort=0.
  - Internal accumulator, watchdog and warm-up counter all 0.
- Reset mid-frame discards the partial count; no num_valid is issued.
- FSM states: IDLE, COUNT, PUBLISH.
- IDLE:
  - frame_start -> COUNT; accumulator = popcount(kp_valid) of that same cycle; watchdog=0; cnt_overflow=0.
  - frame_end and kp_valid are ignored.
- COUNT:
  - Each cycle: accumulator += popcount(kp_valid), saturating at 2^CNT_W-1. If saturation is reached or exceeded, set cnt_overflow.
  - Watchdog increments each cycle.
  - frame_end -> PUBLISH. kp_valid in the frame_end cycle is counted.
  - frame_start without frame_end -> restart. Pulse frame_abort; accumulator = popcount(kp_valid) of that cycle; watchdog=0; stay in COUNT. No publish.
  - frame_start and frame_end in the same cycle -> close the current frame (go to PUBLISH). The new frame_start is latched as a pending start.
  - Watchdog reaches TIMEOUT_CYCLES-1 without frame_end -> pulse frame_abort, go to IDLE, no publish.
- PUBLISH (one cycle):
  - keypoint_num <= accumulator; num_valid=1.
  - Warm-up counter increments, saturating at WARMUP_FRAMES. adaptive_toggle is set when it reaches WARMUP_FRAMES and stays high until reset.
  - Next state: COUNT if a start is pending or frame_start is high in this cycle, with the accumulator loaded with popcount(kp_valid) of this cycle; otherwise IDLE. kp_valid in the PUBLISH cycle is not counted unless that cycle starts a frame.
- Latency: keypoint_num and num_valid are visible 1 cycle after the clk edge that samples frame_end. keypoint_num holds between publishes.
- frame_active = (state==COUNT).
- Popcount is combinational over LANES bits. The sum is computed at CNT_W+1 bits, then clamped.

Optional Feature:
Macro KP_AVG_EN.
- Defined:
  - Adds output kp_avg [CNT_W-1:0]: the mean of the last 4 published counts. A 4-entry history is shifted on each PUBLISH; sum is CNT_W+2 bits, right-shifted by 2, truncated.
  - History entries reset to 0, so the first 3 frames average in zeros.
  - kp_avg updates in the cycle after num_valid.
- Not defined: no history registers and no kp_avg port; all other behaviour identical.

Test Plan:
1. Reset, frame_start, 10 cycles with kp_valid=2'b11, frame_end -> 1 cycle later keypoint_num=20, num_valid pulses once, adaptive_toggle=1.
2. 1100 cycles of kp_valid=2'b11 in one frame -> keypoint_num=2047, cnt_overflow=1; next frame_start clears cnt_overflow.
3. frame_start, 5 keypoints, second frame_start, 3 keypoints, frame_end -> frame_abort pulses once; keypoint_num=3.
4. frame_start and frame_end in the same cycle during an open frame of 7 keypoints -> keypoint_num=7 published; new frame open (frame_active=1); its count starts from popcount of that publish cycle.
5. TIMEOUT_CYCLES=16, frame_start with no frame_end -> frame_abort at cycle 16, state IDLE, keypoint_num unchanged, no num_valid; rst_n low mid-frame -> all outputs return to reset values.
6. KP_AVG_EN defined, publishes 100, 200, 300, 400 -> kp_avg 25, 75, 150, 250; a fifth publish of 0 -> kp_avg=225.
